// File: rtl/fp_tile_pkg.sv
// Shared types and helpers for the FP divider tile operand front end.
package fp_tile_pkg;

    localparam int FP_BW      = 32;
    localparam int FP_BWB     = FP_BW / 8;
    localparam int FP_CNT_W   = 32;
    // Top bit of the exponent; bits [FP_EXP_MSB:0] are magnitude (sign excluded).
    localparam int FP_EXP_MSB = FP_BW - 2;

    // One operand beat as it sits in a lane FIFO.
    typedef struct packed {
        logic [FP_BW-1:0]  data;
        logic [FP_BWB-1:0] keep;
        logic              last;
    } fp_beat_t;

    // Debug/status readout for the control bus.
    typedef struct packed {
        logic [FP_CNT_W-1:0] pair_count;
        logic [FP_CNT_W-1:0] zero_div_count;
        logic                last_mismatch;
    } pair_status_t;

    // True for +0 and -0: exponent and mantissa all zero, sign ignored.
    function automatic logic is_fp_zero(input logic [FP_BW-1:0] value);
        return (value[FP_EXP_MSB:0] == {(FP_EXP_MSB + 1){1'b0}});
    endfunction

    // Saturating increment; a counter at all-ones stays there.
    function automatic logic [FP_CNT_W-1:0] sat_inc(input logic [FP_CNT_W-1:0] value);
        if (value == {FP_CNT_W{1'b1}}) begin
            return value;
        end else begin
            return value + {{(FP_CNT_W - 1){1'b0}}, 1'b1};
        end
    endfunction

endpackage

// File: rtl/fp_pair_fifo.sv
// Single-clock FIFO of operand beats with registered occupancy count.
module fp_pair_fifo
    import fp_tile_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  fp_beat_t                 wr_data,
    input  logic                     rd_en,
    output fp_beat_t                 rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int            AW        = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE   = {{(AW - 1){1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_ONE   = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_ZERO  = {(AW + 1){1'b0}};
    localparam logic [AW:0]   CNT_FULL  = (AW + 1)'(DEPTH);

    fp_beat_t      mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          push_s;
    logic          pop_s;

    assign full    = (count_r == CNT_FULL);
    assign empty   = (count_r == CNT_ZERO);
    assign count   = count_r;
    assign rd_data = mem_r[rd_ptr_r];

    // Guard the strobes so a misbehaving caller cannot overrun or underrun.
    always_comb begin
        push_s = 1'b0;
        pop_s  = 1'b0;
        if (wr_en && !full) begin
            push_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end
        if (rd_en && !empty) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
    end

    // Storage array; contents are only observable through a valid pop.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= CNT_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/fp_operand_pairer.sv
// Joins the dividend (A) and divisor (B) AXI-Stream lanes into one paired beat
// per division, with per-lane skew buffering and status counters.
module fp_operand_pairer
    import fp_tile_pkg::*;
#(
    parameter int BW    = FP_BW,
    parameter int BWB   = BW / 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = FP_CNT_W
) (
    input  logic               clk_line,
    input  logic               clk_line_rst_high,
    input  logic               a_TVALID,
    output logic               a_TREADY,
    input  logic [BW-1:0]      a_TDATA,
    input  logic [BWB-1:0]     a_TKEEP,
    input  logic               a_TLAST,
    input  logic               b_TVALID,
    output logic               b_TREADY,
    input  logic [BW-1:0]      b_TDATA,
    input  logic [BWB-1:0]     b_TKEEP,
    input  logic               b_TLAST,
    output logic               out_TVALID,
    input  logic               out_TREADY,
    output logic [2*BW-1:0]    out_TDATA,
    output logic [2*BWB-1:0]   out_TKEEP,
    output logic               out_TLAST,
    output logic [CNT_W-1:0]   pair_count,
    output logic [CNT_W-1:0]   zero_div_count,
    output logic               last_mismatch
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [AW:0] LANE_FULL = (AW + 1)'(DEPTH);

    fp_beat_t      a_in_s;
    fp_beat_t      b_in_s;
    fp_beat_t      a_head_s;
    fp_beat_t      b_head_s;
    logic          a_full_s;
    logic          b_full_s;
    logic          a_empty_s;
    logic          b_empty_s;
    logic [AW:0]   a_count_s;
    logic [AW:0]   b_count_s;
    logic          a_push_s;
    logic          b_push_s;
    logic          fire_s;
    logic          out_hs_s;

    logic          ready_en_r;
    logic          out_valid_r;
    logic [2*BW-1:0]  out_data_r;
    logic [2*BWB-1:0] out_keep_r;
    logic          out_last_r;
    pair_status_t  status_r;

    assign a_in_s = '{data: a_TDATA, keep: a_TKEEP, last: a_TLAST};
    assign b_in_s = '{data: b_TDATA, keep: b_TKEEP, last: b_TLAST};

    // Ready comes from the registered occupancy, so a pop in the same cycle never
    // reopens a full lane; ready_en_r holds both lanes off through reset.
    assign a_TREADY = ready_en_r && (a_count_s != LANE_FULL);
    assign b_TREADY = ready_en_r && (b_count_s != LANE_FULL);
    assign a_push_s = a_TVALID && a_TREADY && !a_full_s;
    assign b_push_s = b_TVALID && b_TREADY && !b_full_s;
    assign out_hs_s = out_valid_r && out_TREADY;

    fp_pair_fifo #(.DEPTH(DEPTH)) u_fifo_a (
        .clk     (clk_line),
        .rst     (clk_line_rst_high),
        .wr_en   (a_push_s),
        .wr_data (a_in_s),
        .rd_en   (fire_s),
        .rd_data (a_head_s),
        .full    (a_full_s),
        .empty   (a_empty_s),
        .count   (a_count_s)
    );

    fp_pair_fifo #(.DEPTH(DEPTH)) u_fifo_b (
        .clk     (clk_line),
        .rst     (clk_line_rst_high),
        .wr_en   (b_push_s),
        .wr_data (b_in_s),
        .rd_en   (fire_s),
        .rd_data (b_head_s),
        .full    (b_full_s),
        .empty   (b_empty_s),
        .count   (b_count_s)
    );

    // Join: both lanes have a head entry and the output register is free or draining.
    always_comb begin
        fire_s = 1'b0;
        if (!a_empty_s && !b_empty_s && (!out_valid_r || out_TREADY)) begin
            fire_s = 1'b1;
        end else begin
            fire_s = 1'b0;
        end
    end

    // Lane ready enable: low while reset is applied, high from the first cycle after.
    always_ff @(posedge clk_line) begin
        if (clk_line_rst_high) begin
            ready_en_r <= 1'b0;
        end else begin
            ready_en_r <= 1'b1;
        end
    end

    // Output register: load on fire, retire on handshake, otherwise hold stable.
    always_ff @(posedge clk_line) begin
        if (clk_line_rst_high) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {(2 * BW){1'b0}};
            out_keep_r  <= {(2 * BWB){1'b0}};
            out_last_r  <= 1'b0;
        end else if (fire_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= {b_head_s.data, a_head_s.data};
            out_keep_r  <= {b_head_s.keep, a_head_s.keep};
            out_last_r  <= a_head_s.last | b_head_s.last;
        end else if (out_hs_s) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Status: saturating counters on downstream handshake, sticky TLAST mismatch on fire.
    always_ff @(posedge clk_line) begin
        if (clk_line_rst_high) begin
            status_r <= {$bits(pair_status_t){1'b0}};
        end else begin
            if (out_hs_s) begin
                status_r.pair_count <= sat_inc(status_r.pair_count);
                if (is_fp_zero(out_data_r[2*BW-1:BW])) begin
                    status_r.zero_div_count <= sat_inc(status_r.zero_div_count);
                end
            end
            if (fire_s && (a_head_s.last != b_head_s.last)) begin
                status_r.last_mismatch <= 1'b1;
            end
        end
    end

    assign out_TVALID     = out_valid_r;
    assign out_TDATA      = out_data_r;
    assign out_TKEEP      = out_keep_r;
    assign out_TLAST      = out_last_r;
    assign pair_count     = status_r.pair_count;
    assign zero_div_count = status_r.zero_div_count;
    assign last_mismatch  = status_r.last_mismatch;

endmodule

// File: tb/tb_fp_operand_pairer.sv
// Directed self-checking bench for fp_operand_pairer.
module tb_fp_operand_pairer;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        a_TVALID, a_TREADY, a_TLAST;
    logic [31:0] a_TDATA;
    logic [3:0]  a_TKEEP;
    logic        b_TVALID, b_TREADY, b_TLAST;
    logic [31:0] b_TDATA;
    logic [3:0]  b_TKEEP;
    logic        out_TVALID, out_TREADY, out_TLAST;
    logic [63:0] out_TDATA;
    logic [7:0]  out_TKEEP;
    logic [31:0] pair_count, zero_div_count;
    logic        last_mismatch;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    logic [31:0] st_a [5] = '{32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000, 32'h40E00000};
    logic [31:0] st_b [5] = '{32'h3F800000, 32'h3F800000, 32'h40000000, 32'h40000000, 32'h40400000};

    fp_operand_pairer dut (
        .clk_line          (clk),
        .clk_line_rst_high (rst),
        .a_TVALID          (a_TVALID),
        .a_TREADY          (a_TREADY),
        .a_TDATA           (a_TDATA),
        .a_TKEEP           (a_TKEEP),
        .a_TLAST           (a_TLAST),
        .b_TVALID          (b_TVALID),
        .b_TREADY          (b_TREADY),
        .b_TDATA           (b_TDATA),
        .b_TKEEP           (b_TKEEP),
        .b_TLAST           (b_TLAST),
        .out_TVALID        (out_TVALID),
        .out_TREADY        (out_TREADY),
        .out_TDATA         (out_TDATA),
        .out_TKEEP         (out_TKEEP),
        .out_TLAST         (out_TLAST),
        .pair_count        (pair_count),
        .zero_div_count    (zero_div_count),
        .last_mismatch     (last_mismatch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_cmp++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input logic [31:0] d, input logic [3:0] k, input logic l);
        int   n;
        logic ok;
        n  = 0;
        ok = 1'b0;
        a_TVALID = 1'b1; a_TDATA = d; a_TKEEP = k; a_TLAST = l;
        while (!ok && n < 64) begin
            @(negedge clk);
            ok = a_TREADY;
            tick();
            n++;
        end
        a_TVALID = 1'b0;
        if (!ok) check("push_a_timeout", 64'(ok), 64'd1);
    endtask

    task automatic push_b(input logic [31:0] d, input logic [3:0] k, input logic l);
        int   n;
        logic ok;
        n  = 0;
        ok = 1'b0;
        b_TVALID = 1'b1; b_TDATA = d; b_TKEEP = k; b_TLAST = l;
        while (!ok && n < 64) begin
            @(negedge clk);
            ok = b_TREADY;
            tick();
            n++;
        end
        b_TVALID = 1'b0;
        if (!ok) check("push_b_timeout", 64'(ok), 64'd1);
    endtask

    task automatic push_pair(input logic [31:0] ad, input logic [31:0] bd,
                             input logic al, input logic bl);
        exp_q.push_back('{{bd, ad}, {4'h3, 4'hF}, al | bl});
        fork
            push_a(ad, 4'hF, al);
            push_b(bd, 4'h3, bl);
        join
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    // Scoreboard: every downstream handshake must match the next expected pair.
    always @(negedge clk) begin
        if (!rst && out_TVALID && out_TREADY) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 64'd1, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("pair_data", out_TDATA, mon_e.data);
                check("pair_keep", 64'(out_TKEEP), 64'(mon_e.keep));
                check("pair_last", 64'(out_TLAST), 64'(mon_e.last));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; out_TREADY = 1'b0;
        a_TVALID = 1'b0; a_TDATA = 32'h0; a_TKEEP = 4'h0; a_TLAST = 1'b0;
        b_TVALID = 1'b0; b_TDATA = 32'h0; b_TKEEP = 4'h0; b_TLAST = 1'b0;

        // Reset state
        repeat (3) tick();
        @(negedge clk);
        check("rst_valid", 64'(out_TVALID), 64'd0);
        check("rst_data", out_TDATA, 64'd0);
        check("rst_pcount", 64'(pair_count), 64'd0);
        check("rst_a_ready", 64'(a_TREADY), 64'd0);
        check("rst_b_ready", 64'(b_TREADY), 64'd0);
        tick();
        rst = 1'b0;
        out_TREADY = 1'b1;
        @(negedge clk);
        check("ready_still_low", 64'(a_TREADY), 64'd0);
        tick();
        @(negedge clk);
        check("ready_rise_a", 64'(a_TREADY), 64'd1);
        check("ready_rise_b", 64'(b_TREADY), 64'd1);
        tick();

        // Aligned streams with latency check
        exp_q.push_back('{64'h3F800000_40000000, 8'h3F, 1'b0});
        exp_q.push_back('{64'h40000000_41000000, 8'h3F, 1'b0});
        a_TVALID = 1'b1; a_TDATA = 32'h40000000; a_TKEEP = 4'hF; a_TLAST = 1'b0;
        b_TVALID = 1'b1; b_TDATA = 32'h3F800000; b_TKEEP = 4'h3; b_TLAST = 1'b0;
        tick();
        a_TDATA = 32'h41000000;
        b_TDATA = 32'h40000000;
        @(negedge clk);
        check("lat_t1_valid", 64'(out_TVALID), 64'd0);
        tick();
        a_TVALID = 1'b0; b_TVALID = 1'b0;
        @(negedge clk);
        check("lat_t2_valid", 64'(out_TVALID), 64'd1);
        check("lat_t2_data", out_TDATA, 64'h3F800000_40000000);
        tick();
        @(negedge clk);
        check("aligned_2nd", out_TDATA, 64'h40000000_41000000);
        tick();
        @(negedge clk);
        check("aligned_idle", 64'(out_TVALID), 64'd0);
        check("aligned_pcount", 64'(pair_count), 64'd2);
        tick();

        // Skew: A leads by DEPTH beats
        exp_q.push_back('{64'h40400000_42000000, 8'h3F, 1'b0});
        exp_q.push_back('{64'h40800000_42040000, 8'h3F, 1'b0});
        exp_q.push_back('{64'h40A00000_42080000, 8'h3F, 1'b0});
        exp_q.push_back('{64'h40C00000_420C0000, 8'h3F, 1'b0});
        push_a(32'h42000000, 4'hF, 1'b0);
        push_a(32'h42040000, 4'hF, 1'b0);
        push_a(32'h42080000, 4'hF, 1'b0);
        push_a(32'h420C0000, 4'hF, 1'b0);
        @(negedge clk);
        check("skew_a_ready_low", 64'(a_TREADY), 64'd0);
        check("skew_no_valid", 64'(out_TVALID), 64'd0);
        tick();
        push_b(32'h40400000, 4'h3, 1'b0);
        push_b(32'h40800000, 4'h3, 1'b0);
        push_b(32'h40A00000, 4'h3, 1'b0);
        push_b(32'h40C00000, 4'h3, 1'b0);
        wait_drain();
        @(negedge clk);
        check("skew_a_ready_back", 64'(a_TREADY), 64'd1);
        check("skew_pcount", 64'(pair_count), 64'd6);
        tick();

        // Output stall: fill output register and both FIFOs
        out_TREADY = 1'b0;
        for (int i = 0; i < 5; i++) exp_q.push_back('{{st_b[i], st_a[i]}, 8'h3F, 1'b0});
        fork
            for (int i = 0; i < 5; i++) push_a(st_a[i], 4'hF, 1'b0);
            for (int j = 0; j < 5; j++) push_b(st_b[j], 4'h3, 1'b0);
        join
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_valid", 64'(out_TVALID), 64'd1);
            check("stall_data", out_TDATA, 64'h3F800000_40400000);
            check("stall_a_ready", 64'(a_TREADY), 64'd0);
            check("stall_b_ready", 64'(b_TREADY), 64'd0);
            tick();
        end
        out_TREADY = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stream_valid", 64'(out_TVALID), 64'd1);
            tick();
        end
        @(negedge clk);
        check("stream_end", 64'(out_TVALID), 64'd0);
        check("stall_pcount", 64'(pair_count), 64'd11);
        tick();
        wait_drain();

        // Zero divisor detection, sign ignored
        push_pair(32'h3F800000, 32'h80000000, 1'b0, 1'b0);
        push_pair(32'h3F800000, 32'h00000000, 1'b0, 1'b0);
        wait_drain();
        check("zero_two", 64'(zero_div_count), 64'd2);
        push_pair(32'h40000000, 32'h00000001, 1'b0, 1'b0);
        wait_drain();
        check("zero_denorm", 64'(zero_div_count), 64'd2);
        check("zero_pcount", 64'(pair_count), 64'd14);

        // TLAST mismatch on beat 3, sticky afterwards
        check("mm_clear", 64'(last_mismatch), 64'd0);
        push_pair(32'h41000000, 32'h40000000, 1'b0, 1'b0);
        push_pair(32'h41100000, 32'h40000000, 1'b0, 1'b0);
        push_pair(32'h41200000, 32'h40000000, 1'b1, 1'b0);
        push_pair(32'h41300000, 32'h40000000, 1'b0, 1'b0);
        wait_drain();
        check("mm_set", 64'(last_mismatch), 64'd1);
        push_pair(32'h41400000, 32'h40000000, 1'b1, 1'b1);
        wait_drain();
        check("mm_sticky", 64'(last_mismatch), 64'd1);
        check("mm_pcount", 64'(pair_count), 64'd19);

        // Reset mid-stream with beats buffered and output valid
        out_TREADY = 1'b0;
        push_pair(32'h42000000, 32'h41000000, 1'b0, 1'b0);
        push_pair(32'h42100000, 32'h41000000, 1'b0, 1'b0);
        push_pair(32'h42200000, 32'h41000000, 1'b0, 1'b0);
        push_pair(32'h42300000, 32'h41000000, 1'b0, 1'b0);
        @(negedge clk);
        check("pre_rst_valid", 64'(out_TVALID), 64'd1);
        tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        check("mrst_valid", 64'(out_TVALID), 64'd0);
        check("mrst_data", out_TDATA, 64'd0);
        check("mrst_keep", 64'(out_TKEEP), 64'd0);
        check("mrst_last", 64'(out_TLAST), 64'd0);
        check("mrst_pcount", 64'(pair_count), 64'd0);
        check("mrst_zcount", 64'(zero_div_count), 64'd0);
        check("mrst_mm", 64'(last_mismatch), 64'd0);
        check("mrst_a_ready", 64'(a_TREADY), 64'd0);
        check("mrst_b_ready", 64'(b_TREADY), 64'd0);
        exp_q.delete();
        tick();
        rst = 1'b0;
        out_TREADY = 1'b1;
        push_pair(32'h3F000000, 32'h3E800000, 1'b0, 1'b0);
        wait_drain();
        @(negedge clk);
        check("post_rst_data", out_TDATA, 64'h3E800000_3F000000);
        check("post_rst_pcount", 64'(pair_count), 64'd1);
        check("post_rst_idle", 64'(out_TVALID), 64'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fp_operand_pairer.md
Name: fp_operand_pairer

Overview:
- Upstream stage of the FP divider tile; joins two independent AXI-Stream operand lanes (dividend lane A, divisor lane B) into one paired beat per division.
- Each lane is buffered in a small FIFO so the two producers may run skewed.
- The paired beat leaves through a single registered output stage.
- Also reports TLAST misalignment between lanes and counts zero divisors, for debug/status readout over the control bus.

Parameters:
- BW, 32, operand width in bits (IEEE-754 single).
- BWB, BW/8, keep width per operand.
- DEPTH, 4, per-lane FIFO depth (power of two, >=2).
- CNT_W, 32, width of the status counters.

Ports:
- clk_line  in  1  line clock; the only clock.
- clk_line_rst_high  in  1  reset, synchronous, active-high.
- a_TVALID / a_TREADY  in / out  1 / 1  lane A (dividend) handshake.
- a_TDATA / a_TKEEP / a_TLAST  in  BW / BWB / 1  lane A payload.
- b_TVALID / b_TREADY  in / out  1 / 1  lane B (divisor) handshake.
- b_TDATA / b_TKEEP / b_TLAST  in  BW / BWB / 1  lane B payload.
- out_TVALID  out  1  paired beat valid.
- out_TREADY  in  1  downstream (divider) ready.
- out_TDATA  out  2*BW  {divisor, dividend}; divisor in the upper half.
- out_TKEEP  out  2*BWB  {b_keep, a_keep}.
- out_TLAST  out  1  a_last OR b_last.
- pair_count  out  CNT_W  number of paired beats accepted downstream.
- zero_div_count  out  CNT_W  number of paired beats whose divisor is +/-0.
- last_mismatch  out  1  sticky; set when a_last != b_last in a pair.

Behaviour:
- Reset: when clk_line_rst_high is sampled high, both FIFOs empty, output register empty, and all of the following are 0: out_TVALID, out_TDATA, out_TKEEP, out_TLAST, counters, last_mismatch, a_TREADY, b_TREADY.
- Reset mid-operation discards all buffered and in-flight beats. TREADY rises the first cycle after reset deasserts.
- Lane accept: x_TREADY = !fifo_x_full, driven from a registered occupancy count. A beat is written on x_TVALID && x_TREADY.
- Full FIFO: TREADY stays low even if a pop happens in the same cycle (no same-cycle passthrough).
- Join condition: fire = !empty_a && !empty_b && (!out_TVALID || out_TREADY). On fire, pop one entry from each FIFO in the same cycle and load the output register; out_TVALID = 1 next cycle.
- No-fire cycles: if out_TVALID && out_TREADY, out_TVALID clears. Otherwise the output holds stable (AXI rule: data must not change while valid && !ready).
- Latency: from the cycle the later of the two lane handshakes occurs (cycle t), out_TVALID is high at t+2 when the output is free. Sustained throughput is 1 pair/cycle with out_TREADY held high.
- Lane skew: one lane may lead by up to DEPTH beats. Beyond that its TREADY drops; no deadlock and no data loss.
- Pairing is strictly FIFO order: the n-th A beat is paired with the n-th B beat.
- pair_count increments on out_TVALID && out_TREADY.
- zero_div_count increments on the same handshake when divisor[BW-2:0] == 0 (sign ignored).
- Both counters saturate at all-ones and never wrap.
- last_mismatch sets on fire when the popped a_last != b_last and clears only on reset. out_TLAST is still the OR of the two.
- TKEEP is passed through unchecked; it does not affect pairing.

Decomposition:
- Shared package fp_tile_pkg:
  - typedef fp_beat_t {logic [BW-1:0] data; logic [BWB-1:0] keep; logic last;}
  - constant FP_EXP_MSB for zero detection
  - typedef pair_status_t grouping the counters and the sticky flag.
- Sub-module fp_pair_fifo:
  - synchronous single-clock FIFO of fp_beat_t, parameter DEPTH.
  - outputs full, empty, registered count.
  - instantiated twice, once per lane.
- The join logic and output register stay in the top module.

Test Plan:
- Aligned streams: A = 0x40000000 then 0x41000000, B = 0x3F800000 then 0x40000000, out_TREADY = 1 → out_TDATA = 0x3F800000_40000000 at t+2, then 0x40000000_41000000; pair_count = 2.
- Skew/backpressure: drive 4 A beats with B idle → a_TREADY low after the 4th, out_TVALID stays 0. Then send 4 B beats → 4 pairs in order; a_TREADY returns high.
- Output stall: hold out_TREADY = 0 for 5 cycles with both lanes valid → out_TDATA stable and out_TVALID held; both FIFOs fill and TREADY drops. Release → 1 pair/cycle, no beat lost or duplicated.
- Zero divisor: B = 0x80000000 and 0x00000000 → zero_div_count = 2. B = 0x00000001 → no increment.
- TLAST mismatch: a_last = 1, b_last = 0 on beat 3 → last_mismatch = 1, out_TLAST = 1; flag stays set through later aligned beats until reset.
- Reset mid-stream: assert reset with 3 entries buffered and out_TVALID = 1 → next cycle all outputs and counters are 0. After release, the first new pair emerges with no stale data.
